// File: rtl/memory_game_pkg.sv
// Shared encodings and helpers for the pattern-memory game core and its LFSR.
package memory_game_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GEN      = 3'd1;
  localparam logic [2:0] S_SHOW_ON  = 3'd2;
  localparam logic [2:0] S_SHOW_OFF = 3'd3;
  localparam logic [2:0] S_INPUT    = 3'd4;
  localparam logic [2:0] S_ROUND_OK = 3'd5;
  localparam logic [2:0] S_WIN      = 3'd6;
  localparam logic [2:0] S_LOSE     = 3'd7;

  // Feedback taps for x^16+x^14+x^13+x^11 on a left-shifting Fibonacci register.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int ONEHOT_W = 32;

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [4:0] idx);
    logic [ONEHOT_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/memory_game_if.sv
// Player-facing signal bundle of the game core: timebase, start/level, buttons, LEDs, status.
interface memory_game_if #(
  parameter int N_BTN   = 8,
  parameter int SCORE_W = 4
);
  import memory_game_pkg::*;

  logic               tick;
  logic               start;
  logic [1:0]         level;
  logic [N_BTN-1:0]   btn;
  logic [N_BTN-1:0]   led;
  logic [SCORE_W-1:0] score;
  logic               busy;
  logic               win;
  logic               lose;

  modport master (output tick, start, level, btn, input led, score, busy, win, lose);
  modport slave  (input tick, start, level, btn, output led, score, busy, win, lose);

endinterface

// File: rtl/memory_game_lfsr.sv
// 16-bit Fibonacci LFSR; free-running so pattern entropy comes from player timing.
module game_lfsr
  import memory_game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_2,
  input  logic        rst_n,
  input  logic        step,
  output logic [15:0] q
);

  always_ff @(posedge clk_2) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (step) begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/memory_game_core.sv
// Pattern-memory game controller: generate a random sequence, show it on LEDs, check replay.
module memory_game_core
  import memory_game_pkg::*;
#(
  parameter int          N_BTN         = 8,
  parameter int          SEQ_MAX       = 16,
  parameter int          BASE_LEN      = 4,
  parameter int          ROUNDS        = 11,
  parameter int          SHOW_TICKS    = 8,
  parameter int          TIMEOUT_TICKS = 50,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input logic          clk_2,
  input logic          rst_n,
  memory_game_if.slave bus
);

  localparam int PAT_W   = $clog2(N_BTN);
  localparam int IDX_W   = $clog2(SEQ_MAX);
  localparam int SCORE_W = $clog2(ROUNDS + 1);
  localparam int SHOW_W  = $clog2(SHOW_TICKS + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_TICKS + 1);

  logic [2:0]         r_state;
  logic [PAT_W-1:0]   r_pat [SEQ_MAX];
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_last;
  logic [SHOW_W-1:0]  r_on_t;
  logic [SHOW_W-1:0]  r_off_t;
  logic [SHOW_W-1:0]  r_tcnt;
  logic [TMO_W-1:0]   r_timer;
  logic [SCORE_W-1:0] r_score;
  logic               r_start_prev;
  logic [N_BTN-1:0]   r_btn_prev;
  logic [N_BTN-1:0]   r_evt;

  logic [15:0]        w_lfsr;
  logic [PAT_W-1:0]   w_gen_val;
  logic [N_BTN-1:0]   w_expect;
  logic               w_start_edge;
  logic               w_is_last;
  logic [IDX_W-1:0]   w_last_idx;
  logic [SHOW_W-1:0]  w_on_t;
  logic [SHOW_W-1:0]  w_off_t;

  game_lfsr #(.SEED(SEED)) u_lfsr (
    .clk_2 (clk_2),
    .rst_n (rst_n),
    .step  (1'b1),
    .q     (w_lfsr)
  );

  // Difficulty-derived length and show timing; latched only when a start edge is accepted.
  always_comb begin : derive_level
    int len_i;
    int on_i;
    len_i = BASE_LEN + 2 * int'(bus.level);
    if (len_i > SEQ_MAX) len_i = SEQ_MAX;
    on_i = SHOW_TICKS >> bus.level;
    if (on_i < 1) on_i = 1;
    w_last_idx = IDX_W'(len_i - 1);
    w_on_t     = SHOW_W'(on_i);
    w_off_t    = (on_i / 2 < 1) ? SHOW_W'(1) : SHOW_W'(on_i / 2);
  end

  assign w_start_edge = bus.start & ~r_start_prev;
  assign w_is_last    = (r_idx == r_last);
  assign w_gen_val    = PAT_W'({16'd0, w_lfsr} % N_BTN);
  assign w_expect     = N_BTN'(onehot(5'(r_pat[r_idx])));

  always_ff @(posedge clk_2) begin
    if (rst_n && r_state == S_GEN) begin
      r_pat[r_idx] <= w_gen_val;
    end
  end

  // Press events are registered one cycle so that the FSM acts two cycles after the button edge.
  always_ff @(posedge clk_2) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_last       <= '0;
      r_on_t       <= '0;
      r_off_t      <= '0;
      r_tcnt       <= '0;
      r_timer      <= '0;
      r_score      <= '0;
      r_start_prev <= 1'b0;
      r_btn_prev   <= '0;
      r_evt        <= '0;
    end else begin
      r_start_prev <= bus.start;
      r_btn_prev   <= bus.btn;
      r_evt        <= bus.btn & ~r_btn_prev;
      case (r_state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (w_start_edge) begin
            r_state <= S_GEN;
            r_score <= '0;
            r_idx   <= '0;
            r_last  <= w_last_idx;
            r_on_t  <= w_on_t;
            r_off_t <= w_off_t;
          end
        end
        S_GEN: begin
          if (w_is_last) begin
            r_state <= S_SHOW_ON;
            r_idx   <= '0;
            r_tcnt  <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_SHOW_ON: begin
          if (bus.tick) begin
            if (r_tcnt == r_on_t - SHOW_W'(1)) begin
              r_state <= S_SHOW_OFF;
              r_tcnt  <= '0;
            end else begin
              r_tcnt <= r_tcnt + SHOW_W'(1);
            end
          end
        end
        S_SHOW_OFF: begin
          if (bus.tick) begin
            if (r_tcnt == r_off_t - SHOW_W'(1)) begin
              r_tcnt <= '0;
              if (w_is_last) begin
                r_state <= S_INPUT;
                r_idx   <= '0;
                r_timer <= '0;
              end else begin
                r_state <= S_SHOW_ON;
                r_idx   <= r_idx + IDX_W'(1);
              end
            end else begin
              r_tcnt <= r_tcnt + SHOW_W'(1);
            end
          end
        end
        // A press always takes priority over a coincident tick or timeout.
        S_INPUT: begin
          if (|r_evt) begin
            if (r_evt == w_expect) begin
              r_timer <= '0;
              if (w_is_last) r_state <= S_ROUND_OK;
              else           r_idx   <= r_idx + IDX_W'(1);
            end else begin
              r_state <= S_LOSE;
            end
          end else if (bus.tick) begin
            if (r_timer == TMO_W'(TIMEOUT_TICKS - 1)) r_state <= S_LOSE;
            else                                      r_timer <= r_timer + TMO_W'(1);
          end
        end
        S_ROUND_OK: begin
          r_score <= r_score + SCORE_W'(1);
          if (r_score == SCORE_W'(ROUNDS - 1)) begin
            r_state <= S_WIN;
          end else begin
            r_state <= S_GEN;
            r_idx   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.led = '0;
    case (r_state)
      S_SHOW_ON: bus.led = w_expect;
      S_INPUT:   bus.led = bus.btn;
      S_WIN:     bus.led = '1;
      default:   bus.led = '0;
    endcase
    bus.busy  = !(r_state == S_IDLE || r_state == S_WIN || r_state == S_LOSE);
    bus.win   = (r_state == S_WIN);
    bus.lose  = (r_state == S_LOSE);
    bus.score = r_score;
  end

endmodule

// File: tb/tb_memory_game_core.sv
// Directed bench for memory_game_core: reset, full win, level-2 timing, wrong/double press, timeout.
module tb_memory_game_core;

  logic       clk_2 = 1'b0;
  logic       rst_n;
  int         checks = 0;
  int         errors = 0;
  int         tickPhase = 0;
  int         seenCnt = 0;
  int         cyc;
  logic [15:0] mLfsr;
  logic [7:0] seenLed [16];
  int         onWidth [16];
  int         offWidth [16];
  logic [7:0] expLed [4];
  logic [7:0] wrongBtn;

  memory_game_if #(.N_BTN(8), .SCORE_W(4)) bus ();

  memory_game_core #(
    .N_BTN(8), .SEQ_MAX(16), .BASE_LEN(4), .ROUNDS(11),
    .SHOW_TICKS(8), .TIMEOUT_TICKS(50), .SEED(16'hACE1)
  ) dut (
    .clk_2 (clk_2),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk_2 = ~clk_2;

  // Independent reference LFSR with the polynomial taps written out explicitly.
  always @(posedge clk_2) begin
    if (!rst_n) mLfsr <= 16'hACE1;
    else        mLfsr <= {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
  end

  // One-cycle tick every 4 clocks, changed just after the rising edge.
  initial begin
    bus.tick = 1'b0;
    forever begin
      @(posedge clk_2);
      #1;
      tickPhase = (tickPhase + 1) % 4;
      bus.tick  = (tickPhase == 0);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] rotl(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  task automatic applyStimulus(input logic [7:0] v);
    @(negedge clk_2);
    bus.btn = v;
    waitCycles(2);
    bus.btn = '0;
    waitCycles(2);
  endtask

  task automatic startGame(input logic [1:0] lvl);
    @(negedge clk_2);
    bus.level = lvl;
    bus.start = 1'b1;
    @(negedge clk_2);
    bus.start = 1'b0;
  endtask

  // Captures len LED pulses with their on/off widths in clock cycles.
  task automatic recordShow(input int len, input bit holdOther);
    int n;
    int onCnt;
    int gapCnt;
    logic [7:0] prev;
    seenCnt = 0;
    n = 0;
    onCnt = 0;
    gapCnt = 0;
    prev = '0;
    while (seenCnt < len && n < 3000) begin
      @(negedge clk_2);
      n++;
      if (bus.led != 0) begin
        if (prev == 0) begin
          if (seenCnt > 0) offWidth[seenCnt-1] = gapCnt;
          seenLed[seenCnt] = bus.led;
          onCnt = 0;
          if (holdOther && seenCnt == 0) bus.btn = rotl(bus.led);
        end
        onCnt++;
      end else begin
        if (prev != 0) begin
          onWidth[seenCnt] = onCnt;
          seenCnt++;
          gapCnt = 0;
        end
        gapCnt++;
      end
      prev = bus.led;
    end
    checkOutput("show_pulse_count", seenCnt, len);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.level = 2'd0;
    bus.btn   = '0;
    waitCycles(3);
    checkOutput("rst_led", bus.led, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_win", bus.win, 0);
    checkOutput("rst_lose", bus.lose, 0);
    checkOutput("rst_score", bus.score, 0);
    rst_n = 1'b1;

    // Reset in the middle of the show phase
    startGame(2'd0);
    cyc = 0;
    while (bus.led == 0 && cyc < 200) begin
      @(negedge clk_2);
      cyc++;
    end
    checkOutput("midshow_led_active", 32'(bus.led != 0), 1);
    checkOutput("midshow_busy", bus.busy, 1);
    rst_n = 1'b0;
    @(negedge clk_2);
    rst_n = 1'b1;
    checkOutput("midrst_led", bus.led, 0);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_score", bus.score, 0);

    // Level 0: first pattern predicted by the reference LFSR, then 11 rounds replayed
    @(negedge clk_2);
    bus.level = 2'd0;
    bus.start = 1'b1;
    @(posedge clk_2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_2);
      expLed[k] = 8'd1 << (mLfsr % 16'd8);
      if (k == 0) bus.start = 1'b0;
    end
    for (int r = 0; r < 11; r++) begin
      recordShow(4, 1'b0);
      if (r == 0) begin
        for (int k = 0; k < 4; k++) checkOutput($sformatf("pattern_r0_%0d", k), seenLed[k], expLed[k]);
      end
      checkOutput($sformatf("score_during_round_%0d", r), bus.score, r);
      waitCycles(24);
      for (int k = 0; k < 4; k++) applyStimulus(seenLed[k]);
    end
    checkOutput("win_flag", bus.win, 1);
    checkOutput("win_led", bus.led, 8'hFF);
    checkOutput("win_busy", bus.busy, 0);
    checkOutput("win_lose", bus.lose, 0);
    checkOutput("win_score", bus.score, 11);

    // Level 2: length 8, on = 2 ticks, off = 1 tick; then a wrong press at idx 2
    startGame(2'd2);
    recordShow(8, 1'b0);
    checkOutput("l2_score_cleared", bus.score, 0);
    checkOutput("l2_busy", bus.busy, 1);
    for (int k = 0; k < 8; k++) checkOutput($sformatf("l2_onehot_%0d", k), $countones(seenLed[k]), 1);
    for (int k = 1; k < 8; k++) checkOutput($sformatf("l2_on_width_%0d", k), onWidth[k], 8);
    for (int k = 0; k < 7; k++) checkOutput($sformatf("l2_off_width_%0d", k), offWidth[k], 4);
    waitCycles(12);
    applyStimulus(seenLed[0]);
    applyStimulus(seenLed[1]);
    checkOutput("l2_alive_after_two", bus.lose, 0);
    wrongBtn = rotl(seenLed[2]);
    @(negedge clk_2);
    bus.btn = wrongBtn;
    @(negedge clk_2);
    checkOutput("wrong_lat1_lose", bus.lose, 0);
    @(negedge clk_2);
    checkOutput("wrong_lat2_lose", bus.lose, 1);
    checkOutput("wrong_score", bus.score, 0);
    checkOutput("wrong_busy", bus.busy, 0);
    checkOutput("wrong_led", bus.led, 0);
    bus.btn = '0;

    // Two buttons rising together
    startGame(2'd0);
    recordShow(4, 1'b0);
    waitCycles(24);
    @(negedge clk_2);
    bus.btn = seenLed[0] | rotl(seenLed[0]);
    waitCycles(2);
    checkOutput("two_btn_lose", bus.lose, 1);
    bus.btn = '0;

    // Wrong button held from the show into input must not count as a press
    startGame(2'd0);
    recordShow(4, 1'b1);
    waitCycles(44);
    checkOutput("held_no_lose", bus.lose, 0);
    checkOutput("held_busy", bus.busy, 1);
    bus.btn = '0;
    waitCycles(2);
    for (int k = 0; k < 4; k++) applyStimulus(seenLed[k]);
    checkOutput("held_round_score", bus.score, 1);

    // Timeout: press on the 49th tick restarts the timer, then 50 idle ticks lose
    recordShow(4, 1'b0);
    waitCycles(24);
    cyc = 0;
    do begin
      @(negedge clk_2);
      cyc++;
    end while (bus.tick != 1'b1 && cyc < 8);
    bus.btn = seenLed[0];
    for (int c = 1; c <= 397; c++) begin
      @(negedge clk_2);
      if (c == 2)   bus.btn = '0;
      if (c == 195) bus.btn = seenLed[1];
      if (c == 197) bus.btn = '0;
      if (c == 201) checkOutput("tmo_restarted_no_lose", bus.lose, 0);
      if (c == 396) checkOutput("tmo_tick49_no_lose", bus.lose, 0);
      if (c == 397) checkOutput("tmo_tick50_lose", bus.lose, 1);
    end
    checkOutput("tmo_score", bus.score, 1);
    checkOutput("tmo_busy", bus.busy, 0);
    checkOutput("tmo_led", bus.led, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
